servo_ramp_array: RTL and testbench

Parametrised multi-channel successor to the single-channel servo controller: generates `NUM_CH` independent PWM outputs from one shared period counter. Each channel slews its duty ratio from a loadable start value toward a live target in bounded steps. New behaviours: per-channel enable and load, configurable step size and ramp rate, glitch-free duty updates at period boundaries, and an at-target status. Sits between the control register file and the servo output pins.

---
 rtl/servo_ctrl_pkg.sv | 16 +
 rtl/servo_ramp_channel.sv | 64 ++++++
 rtl/servo_ramp_array.sv | 75 +++++++
 tb/tb_servo_ramp_array.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/servo_ctrl_pkg.sv
// rtl/servo_ctrl_pkg.sv - shared widths and constants for the servo PWM controllers
package servo_ctrl_pkg;

    localparam int DEF_NUM_CH       = 4;
    localparam int DEF_RATIO_W      = 8;
    localparam int DEF_PRESCALE     = 4;
    localparam int DEF_RAMP_PERIODS = 1;
    localparam int DEF_STEP_W       = 4;
    localparam int SERVO_PERIOD     = 2 ** DEF_RATIO_W;

    // Counter width for a modulo-n counter; a modulo-1 counter still needs one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/servo_ramp_channel.sv
// rtl/servo_ramp_channel.sv - one servo channel: ramping ratio, shadowed duty, PWM compare
module servo_ramp_channel
    import servo_ctrl_pkg::*;
#(
    parameter int RATIO_W = DEF_RATIO_W,
    parameter int STEP_W  = DEF_STEP_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic               load,
    input  logic [RATIO_W-1:0] start_ratio,
    input  logic [RATIO_W-1:0] target_ratio,
    input  logic [STEP_W-1:0]  step,
    input  logic [RATIO_W-1:0] pwm_cnt,
    input  logic               boundary,
    input  logic               ramp_fire,
    output logic               pwm,
    output logic               at_target
);

    localparam int EXT_W = RATIO_W + 1;

    logic [RATIO_W-1:0] cur;
    logic [RATIO_W-1:0] duty;
    logic [RATIO_W-1:0] cur_next;
    logic [EXT_W-1:0]   up_sum;
    logic [EXT_W-1:0]   dn_sum;

    // One extra bit keeps the sum/difference from wrapping; a set MSB on the
    // difference means the step went below zero, which is always past the target.
    always_comb begin
        up_sum   = {1'b0, cur} + EXT_W'(step);
        dn_sum   = {1'b0, cur} - EXT_W'(step);
        cur_next = cur;
        if (cur < target_ratio) begin
            cur_next = (up_sum >= {1'b0, target_ratio}) ? target_ratio : up_sum[RATIO_W-1:0];
        end else if (cur > target_ratio) begin
            cur_next = (dn_sum[RATIO_W] || (dn_sum <= {1'b0, target_ratio}))
                       ? target_ratio : dn_sum[RATIO_W-1:0];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cur       <= '0;
            duty      <= '0;
            pwm       <= 1'b0;
            at_target <= 1'b1;
        end else begin
            if (load) begin
                cur <= start_ratio;
            end else if (ramp_fire && enable) begin
                cur <= cur_next;
            end
            if (boundary) begin
                duty <= cur;
            end
            pwm       <= enable && (pwm_cnt < duty);
            at_target <= (cur == target_ratio);
        end
    end

endmodule

// File: rtl/servo_ramp_array.sv
// rtl/servo_ramp_array.sv - multi-channel ramping servo PWM with a shared period counter
module servo_ramp_array
    import servo_ctrl_pkg::*;
#(
    parameter int NUM_CH       = DEF_NUM_CH,
    parameter int RATIO_W      = DEF_RATIO_W,
    parameter int PRESCALE     = DEF_PRESCALE,
    parameter int RAMP_PERIODS = DEF_RAMP_PERIODS,
    parameter int STEP_W       = DEF_STEP_W
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_CH-1:0]         pwm_enable,
    input  logic [NUM_CH-1:0]         load,
    input  logic [NUM_CH*RATIO_W-1:0] start_pwm_ratio,
    input  logic [NUM_CH*RATIO_W-1:0] target_pwm_ratio,
    input  logic [STEP_W-1:0]         ramp_step,
    output logic [NUM_CH-1:0]         pwm_signal,
    output logic [NUM_CH-1:0]         at_target,
    output logic                      period_start
);

    localparam int PRE_W  = cnt_w(PRESCALE);
    localparam int RAMP_W = cnt_w(RAMP_PERIODS);

    logic [PRE_W-1:0]   prescaler;
    logic [RATIO_W-1:0] pwm_cnt;
    logic [RAMP_W-1:0]  ramp_cnt;
    logic               tick;
    logic               boundary;
    logic               ramp_fire;

    assign tick      = (prescaler == PRE_W'(PRESCALE - 1));
    assign boundary  = tick && (pwm_cnt == '1);
    assign ramp_fire = boundary && (ramp_cnt == RAMP_W'(RAMP_PERIODS - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            prescaler    <= '0;
            pwm_cnt      <= '0;
            ramp_cnt     <= '0;
            period_start <= 1'b0;
        end else begin
            prescaler <= tick ? '0 : prescaler + 1'b1;
            if (tick) begin
                pwm_cnt <= pwm_cnt + 1'b1;
            end
            if (boundary) begin
                ramp_cnt <= ramp_fire ? '0 : ramp_cnt + 1'b1;
            end
            period_start <= boundary;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        servo_ramp_channel #(
            .RATIO_W (RATIO_W),
            .STEP_W  (STEP_W)
        ) u_ch (
            .clock        (clock),
            .reset        (reset),
            .enable       (pwm_enable[i]),
            .load         (load[i]),
            .start_ratio  (start_pwm_ratio[i*RATIO_W +: RATIO_W]),
            .target_ratio (target_pwm_ratio[i*RATIO_W +: RATIO_W]),
            .step         (ramp_step),
            .pwm_cnt      (pwm_cnt),
            .boundary     (boundary),
            .ramp_fire    (ramp_fire),
            .pwm          (pwm_signal[i]),
            .at_target    (at_target[i])
        );
    end

endmodule

// File: tb/tb_servo_ramp_array.sv
// tb/tb_servo_ramp_array.sv - directed self-checking bench for servo_ramp_array
module tb_servo_ramp_array;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  pwm_enable;
    logic [3:0]  load;
    logic [31:0] start_pwm_ratio;
    logic [31:0] target_pwm_ratio;
    logic [3:0]  ramp_step;
    logic [3:0]  pwm_signal;
    logic [3:0]  at_target;
    logic        period_start;

    int n_checks = 0;
    int n_fail   = 0;

    int exp_up[9]   = '{20, 24, 28, 32, 36, 40, 44, 48, 50};
    int exp_up_at[9] = '{0, 0, 0, 0, 0, 0, 0, 1, 1};
    int exp_rev[9]  = '{60, 55, 50, 45, 40, 45, 50, 55, 60};

    servo_ramp_array #(
        .NUM_CH       (4),
        .RATIO_W      (8),
        .PRESCALE     (1),
        .RAMP_PERIODS (1),
        .STEP_W       (4)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .pwm_enable       (pwm_enable),
        .load             (load),
        .start_pwm_ratio  (start_pwm_ratio),
        .target_pwm_ratio (target_pwm_ratio),
        .ramp_step        (ramp_step),
        .pwm_signal       (pwm_signal),
        .at_target        (at_target),
        .period_start     (period_start)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_start(input int ch, input int v);
        start_pwm_ratio[ch*8 +: 8] = 8'(v);
    endtask

    task automatic set_target(input int ch, input int v);
        target_pwm_ratio[ch*8 +: 8] = 8'(v);
    endtask

    // Counts high samples of each pin over the 256 cycles starting at period_start.
    task automatic measure(output int hi[4]);
        int guard = 0;
        for (int c = 0; c < 4; c++) hi[c] = 0;
        while (!period_start && guard < 600) begin
            @(negedge clock);
            guard++;
        end
        check("period_start_seen", 32'(period_start), 1);
        for (int k = 0; k < 256; k++) begin
            if (k != 0) @(negedge clock);
            for (int c = 0; c < 4; c++) hi[c] += int'(pwm_signal[c]);
        end
    endtask

    initial begin
        int hi[4];
        int n;

        reset            = 1'b1;
        pwm_enable       = 4'h0;
        load             = 4'h0;
        start_pwm_ratio  = '0;
        target_pwm_ratio = '0;
        ramp_step        = 4'd0;
        repeat (3) @(negedge clock);
        check("reset_pwm", 32'(pwm_signal), 0);
        check("reset_period_start", 32'(period_start), 0);
        check("reset_at_target", 32'(at_target), 4'hF);

        reset = 1'b0;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!period_start && n < 600);
        check("first_period_start", n, 256);

        // Static ratios: 20, 60, 0 and full scale.
        set_start(0, 20);  set_target(0, 20);
        set_start(1, 60);  set_target(1, 60);
        set_start(2, 0);   set_target(2, 0);
        set_start(3, 255); set_target(3, 255);
        pwm_enable = 4'hF;
        load       = 4'hF;
        @(negedge clock);
        load = 4'h0;
        measure(hi);
        check("static_ch0", hi[0], 20);
        check("static_ch1", hi[1], 60);
        check("static_ch2_zero", hi[2], 0);
        check("static_ch3_full", hi[3], 255);
        check("static_at_target", 32'(at_target), 4'hF);

        // Ramp up with clamp on the last step.
        set_target(0, 50);
        ramp_step = 4'd4;
        for (int k = 0; k < 9; k++) begin
            measure(hi);
            check("ramp_up_ch0", hi[0], exp_up[k]);
            check("ramp_up_at0", 32'(at_target[0]), exp_up_at[k]);
        end
        check("ramp_up_hold_ch1", hi[1], 60);

        // Ramp down, then reverse when cur reaches 40.
        set_target(1, 10);
        ramp_step = 4'd5;
        for (int k = 0; k < 9; k++) begin
            measure(hi);
            check("reverse_ch1", hi[1], exp_rev[k]);
            if (k == 3) set_target(1, 60);
        end
        check("reverse_at_target", 32'(at_target), 4'hF);

        // Load coincides with a ramp boundary on ch0.
        set_target(0, 100);
        set_target(1, 80);
        set_start(0, 30);
        load = 4'b0001;
        @(negedge clock);
        load = 4'h0;
        measure(hi);
        check("load_pre_ch0", hi[0], 50);
        check("load_pre_ch1", hi[1], 60);
        measure(hi);
        check("load_wins_ch0", hi[0], 30);
        check("load_other_ch1", hi[1], 65);
        measure(hi);
        check("load_next_ch0", hi[0], 35);
        check("load_next_ch1", hi[1], 70);

        // Reset mid-period while ch0 is high; ch3 disabled across the restart.
        @(negedge clock);
        repeat (10) @(negedge clock);
        check("pre_reset_ch0_high", 32'(pwm_signal[0]), 1);
        reset      = 1'b1;
        pwm_enable = 4'b0111;
        @(negedge clock);
        check("mid_reset_pwm", 32'(pwm_signal), 0);
        check("mid_reset_period_start", 32'(period_start), 0);
        check("mid_reset_at_target", 32'(at_target), 4'hF);
        reset = 1'b0;
        @(negedge clock);
        check("post_reset_at_target", 32'(at_target), 4'b0100);
        n = 1;
        while (!period_start && n < 600) begin
            @(negedge clock);
            n++;
        end
        check("restart_period_start", n, 256);

        measure(hi);
        check("restart_p1", {hi[3][7:0], hi[2][7:0], hi[1][7:0], hi[0][7:0]}, 32'h00000000);
        measure(hi);
        check("restart_p2", {hi[3][7:0], hi[2][7:0], hi[1][7:0], hi[0][7:0]}, 32'h00000505);
        pwm_enable = 4'hF;
        measure(hi);
        check("frozen_p3", {hi[3][7:0], hi[2][7:0], hi[1][7:0], hi[0][7:0]}, 32'h00000A0A);
        measure(hi);
        check("resumed_p4", {hi[3][7:0], hi[2][7:0], hi[1][7:0], hi[0][7:0]}, 32'h05000F0F);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
